// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 request arbiter: FSM state encoding and request opcode.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package l2_arb_pkg;

  // Arbiter sequencing: one L2 transaction in flight at a time
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT,
    RESP
  } arb_state_t;

  // Latched operation per requester; simultaneous read+write resolves to write
  typedef enum logic {
    OP_READ,
    OP_WRITE
  } req_op_t;

endpackage

// File: rtl/l2_request_arbiter_rr_picker.sv
// Round-robin picker: first pending requester after `last`, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; caller samples winner only when any is high.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Scan from last+1 around to last itself; first pending entry wins
  always_comb begin
    winner   = last;
    any      = |pending;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last) + i) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && pending[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the single L2 port among NUM_REQ L1 requesters, round-robin, one transaction at a time.
// Latency: 4 cycles from sampled request pulse to req_ready with an immediately ready L2, +1 per L2 wait cycle.
// Backpressure: one outstanding request per requester; pulses while pending are dropped, except in the clearing RESP cycle.
module l2_request_arbiter
  import l2_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]               req_addr,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]                               req_read,
  input  logic [NUM_REQ-1:0]                               req_write,
  output logic [NUM_REQ-1:0]                               req_ready,
  output logic [NUM_REQ-1:0]                               req_hit,
  output logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_data_out,
  output logic [NUM_REQ-1:0]                               req_valid,
  output logic [ADDR_WIDTH-1:0]                            l2_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]            l2_data_in,
  output logic                                             l2_read,
  output logic                                             l2_write,
  input  logic                                             l2_ready,
  input  logic                                             l2_hit,
  input  logic                                             l2_block_valid,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]            l2_block_data_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t                                         state;
  logic [IDX_W-1:0]                                   last;
  logic [IDX_W-1:0]                                   grant;
  logic [IDX_W-1:0]                                   winner;
  logic                                               any;
  logic [NUM_REQ-1:0]                                 pending;
  logic [NUM_REQ-1:0]                                 clear_vec;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                 pend_addr;
  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] pend_data;
  req_op_t                                            pend_op [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .pending (pending),
    .last    (last),
    .winner  (winner),
    .any     (any)
  );

  // The granted requester's pending bit is released during its RESP cycle
  always_comb begin
    clear_vec = '0;
    if (state == RESP) begin
      clear_vec[grant] = 1'b1;
    end
  end

  // Request capture: a new pulse is taken when idle or in the releasing cycle (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        pend_op[r] <= OP_READ;
      end
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ((req_read[r] || req_write[r]) && (!pending[r] || clear_vec[r])) begin
          pending[r]   <= 1'b1;
          pend_addr[r] <= req_addr[r];
          pend_data[r] <= req_data_in[r];
          pend_op[r]   <= req_write[r] ? OP_WRITE : OP_READ;
        end else if (clear_vec[r]) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

  // Transaction sequencer with registered L2 command and per-requester response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= IDX_W'(NUM_REQ - 1);
      grant        <= '0;
      l2_read      <= 1'b0;
      l2_write     <= 1'b0;
      l2_addr      <= '0;
      l2_data_in   <= '0;
      req_ready    <= '0;
      req_hit      <= '0;
      req_valid    <= '0;
      req_data_out <= '0;
    end else begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant      <= winner;
            last       <= winner;
            l2_read    <= (pend_op[winner] == OP_READ);
            l2_write   <= (pend_op[winner] == OP_WRITE);
            l2_addr    <= pend_addr[winner];
            l2_data_in <= pend_data[winner];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= GAP;
        end
        GAP: begin
          // l2_ready here may still belong to the previous transaction
          state <= WAIT;
        end
        WAIT: begin
          if (l2_ready) begin
            req_ready[grant]    <= 1'b1;
            req_hit[grant]      <= l2_hit;
            req_valid[grant]    <= l2_block_valid;
            req_data_out[grant] <= l2_block_data_out;
            state               <= RESP;
          end
        end
        RESP: begin
          req_ready <= '0;
          req_hit   <= '0;
          req_valid <= '0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboarded bench for l2_request_arbiter with a delay-programmable L2 stub.
// Latency: n/a.
// Backpressure: n/a.
module tb_l2_request_arbiter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 32;
  localparam int NR = 2;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } cmd_t;

  typedef struct {
    int          idx;
    logic        hit;
    logic        valid;
    logic [31:0] word;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0][AW-1:0]         req_addr;
  logic [NR-1:0][BS-1:0][DW-1:0] req_data_in;
  logic [NR-1:0]                 req_read;
  logic [NR-1:0]                 req_write;
  logic [NR-1:0]                 req_ready;
  logic [NR-1:0]                 req_hit;
  logic [NR-1:0][BS-1:0][DW-1:0] req_data_out;
  logic [NR-1:0]                 req_valid;
  logic [AW-1:0]                 l2_addr;
  logic [BS-1:0][DW-1:0]         l2_data_in;
  logic                          l2_read;
  logic                          l2_write;
  logic                          l2_ready;
  logic                          l2_hit;
  logic                          l2_block_valid;
  logic [BS-1:0][DW-1:0]         l2_block_data_out;

  l2_request_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BLOCK_SIZE (BS),
    .NUM_REQ    (NR)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_addr          (req_addr),
    .req_data_in       (req_data_in),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_ready         (req_ready),
    .req_hit           (req_hit),
    .req_data_out      (req_data_out),
    .req_valid         (req_valid),
    .l2_addr           (l2_addr),
    .l2_data_in        (l2_data_in),
    .l2_read           (l2_read),
    .l2_write          (l2_write),
    .l2_ready          (l2_ready),
    .l2_hit            (l2_hit),
    .l2_block_valid    (l2_block_valid),
    .l2_block_data_out (l2_block_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // L2 stub configuration
  int          l2_delay = 2;
  bit          l2_hold  = 1'b0;
  bit          l2_salt  = 1'b0;
  logic [31:0] l2_base  = 32'h0;
  int          l2_cnt   = 0;

  function automatic logic [31:0] rsp_word(input logic [AW-1:0] a);
    return l2_base ^ (l2_salt ? {21'h0, a} : 32'h0);
  endfunction

  function automatic int bad_word(input logic [BS-1:0][DW-1:0] blk, input logic [31:0] w);
    for (int i = 0; i < BS; i++) begin
      if (blk[i] !== w) return i;
    end
    return 0;
  endfunction

  // L2 stub: ready l2_delay cycles after a command, or held high in hold mode
  initial begin
    l2_ready = 1'b0;
    l2_hit = 1'b0;
    l2_block_valid = 1'b0;
    l2_block_data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        l2_cnt = 0;
        l2_ready = 1'b0;
      end else if (l2_hold) begin
        l2_ready = 1'b1;
      end else begin
        l2_ready = 1'b0;
        if (l2_cnt > 0) begin
          l2_cnt--;
          if (l2_cnt == 0) l2_ready = 1'b1;
        end
      end
      if (rst_n && (l2_read || l2_write)) l2_cnt = l2_delay;
      l2_hit = l2_addr[1];
      l2_block_valid = ~l2_addr[2];
      l2_block_data_out = {BS{rsp_word(l2_addr)}};
    end
  end

  // Scoreboard
  cmd_t        exp_cmd[$];
  rsp_t        exp_rsp[$];
  logic [31:0] last_word [NR];
  int          rsp_cyc [NR];
  int          cmd_cyc = 0;
  int          pulse_cyc = 0;
  bit          prev_cmd = 1'b0;
  cmd_t        mon_c;
  rsp_t        mon_e;
  int          mon_k;

  initial begin
    for (int r = 0; r < NR; r++) begin
      last_word[r] = 32'h0;
      rsp_cyc[r] = 0;
    end
    forever begin
      @(negedge clk);
      if (l2_read || l2_write) begin
        chk("cmd_pulse_len", 64'(prev_cmd), 64'(0));
        cmd_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          chk("unexp_cmd", 64'({l2_write, l2_read}), 64'(0));
        end else begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_op", 64'({l2_write, l2_read}), mon_c.wr ? 64'(2) : 64'(1));
          chk("cmd_addr", 64'(l2_addr), 64'(mon_c.addr));
          if (mon_c.wr) begin
            mon_k = bad_word(l2_data_in, mon_c.word);
            chk("cmd_wdata", 64'(l2_data_in[mon_k]), 64'(mon_c.word));
          end
        end
      end
      prev_cmd = l2_read || l2_write;
      if (req_ready != '0) begin
        chk("ready_onehot", 64'($countones(req_ready)), 64'(1));
        for (int r = 0; r < NR; r++) begin
          if (req_ready[r]) begin
            rsp_cyc[r] = cyc;
            if (exp_rsp.size() == 0) begin
              chk("unexp_ready", 64'(req_ready), 64'(0));
            end else begin
              mon_e = exp_rsp.pop_front();
              chk("rsp_idx", 64'(r), 64'(mon_e.idx));
              chk("rsp_hit", 64'(req_hit[r]), 64'(mon_e.hit));
              chk("rsp_valid", 64'(req_valid[r]), 64'(mon_e.valid));
              mon_k = bad_word(req_data_out[r], mon_e.word);
              chk("rsp_data", 64'(req_data_out[r][mon_k]), 64'(mon_e.word));
              last_word[r] = mon_e.word;
            end
          end else begin
            chk("idle_hit", 64'(req_hit[r]), 64'(0));
            chk("idle_valid", 64'(req_valid[r]), 64'(0));
            mon_k = bad_word(req_data_out[r], last_word[r]);
            chk("hold_data", 64'(req_data_out[r][mon_k]), 64'(last_word[r]));
          end
        end
      end
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) last_word[r] = 32'h0;
        prev_cmd = 1'b0;
      end
    end
  end

  task automatic set_req(input int r, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [31:0] w);
    req_read[r] = rd;
    req_write[r] = wr;
    req_addr[r] = a;
    req_data_in[r] = {BS{w}};
  endtask

  task automatic fire();
    @(posedge clk);
    #1;
    pulse_cyc = cyc;
    req_read = '0;
    req_write = '0;
  endtask

  task automatic push_exp(input int r, input bit wr, input logic [AW-1:0] a, input logic [31:0] w);
    cmd_t c;
    rsp_t e;
    c.wr = wr;
    c.addr = a;
    c.word = w;
    e.idx = r;
    e.hit = a[1];
    e.valid = ~a[2];
    e.word = rsp_word(a);
    exp_cmd.push_back(c);
    exp_rsp.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_cmd.size() == 0 && exp_rsp.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_cmd", 64'(exp_cmd.size()), 64'(0));
    chk("drain_rsp", 64'(exp_rsp.size()), 64'(0));
    exp_cmd.delete();
    exp_rsp.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_hit", 64'(req_hit), 64'(0));
    chk("rst_valid", 64'(req_valid), 64'(0));
    chk("rst_l2cmd", 64'({l2_read, l2_write}), 64'(0));
    chk("rst_l2addr", 64'(l2_addr), 64'(0));
    chk("rst_l2din_lo", 64'(l2_data_in[0]), 64'(0));
    chk("rst_l2din_hi", 64'(l2_data_in[BS-1]), 64'(0));
    for (int r = 0; r < NR; r++) begin
      chk("rst_dout", 64'(req_data_out[r][0]), 64'(0));
    end
  endtask

  int          t0;
  int          reps0;
  int          reps1;
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;

  initial begin
    req_read = '0;
    req_write = '0;
    req_addr = '0;
    req_data_in = '0;
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention right after reset: req0 first, then req1
    l2_delay = 2; l2_salt = 1'b1; l2_base = 32'hA5A5_0000;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h101, 32'h0);
    set_req(1, 1'b1, 1'b0, 11'h202, 32'h0);
    push_exp(0, 1'b0, 11'h101, 32'h0);
    push_exp(1, 1'b0, 11'h202, 32'h0);
    fire();
    drain(100);

    // Single read with a slow L2
    l2_delay = 5; l2_salt = 1'b0; l2_base = 32'hDEADBEEF;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h010, 32'h0);
    push_exp(0, 1'b0, 11'h010, 32'h0);
    fire();
    t0 = pulse_cyc;
    drain(100);
    chk("t1_cmd_lat", 64'(cmd_cyc - t0), 64'(1));
    chk("t1_rsp_lat", 64'(rsp_cyc[0] - t0), 64'(7));

    // Write wins over simultaneous read; a pulse while pending is dropped
    l2_delay = 3;
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 11'h020, 32'h12345678);
    push_exp(1, 1'b1, 11'h020, 32'h12345678);
    fire();
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 1'b0, 11'h030, 32'h0);
    fire();
    drain(100);
    repeat (10) @(negedge clk);

    // Fairness: each requester re-pulses in its own RESP cycle
    l2_salt = 1'b1; l2_base = 32'h5A5A_0000; l2_delay = 3;
    a0 = 11'h041; a1 = 11'h082;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, a0, 32'h0);
    set_req(1, 1'b1, 1'b0, a1, 32'h0);
    push_exp(0, 1'b0, a0, 32'h0);
    push_exp(1, 1'b0, a1, 32'h0);
    fire();
    reps0 = 2; reps1 = 2;
    for (int i = 0; i < 400 && (reps0 > 0 || reps1 > 0); i++) begin
      @(negedge clk);
      if (req_ready[0] && reps0 > 0) begin
        a0 = a0 + 11'd3;
        set_req(0, 1'b1, 1'b0, a0, 32'h0);
        push_exp(0, 1'b0, a0, 32'h0);
        reps0--;
        fire();
      end else if (req_ready[1] && reps1 > 0) begin
        a1 = a1 + 11'd5;
        set_req(1, 1'b1, 1'b0, a1, 32'h0);
        push_exp(1, 1'b0, a1, 32'h0);
        reps1--;
        fire();
      end
    end
    chk("t4_repulses_done", 64'(reps0 + reps1), 64'(0));
    drain(200);

    // Stale ready: l2_ready held high throughout
    l2_hold = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h111, 32'h0);
    push_exp(0, 1'b0, 11'h111, 32'h0);
    fire();
    t0 = pulse_cyc;
    drain(100);
    chk("t5_lat_single", 64'(rsp_cyc[0] - t0), 64'(4));
    // last grant was req0, so req1 goes first now
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h122, 32'h0);
    set_req(1, 1'b0, 1'b1, 11'h233, 32'hCAFE0001);
    push_exp(1, 1'b1, 11'h233, 32'hCAFE0001);
    push_exp(0, 1'b0, 11'h122, 32'h0);
    fire();
    t0 = pulse_cyc;
    drain(100);
    chk("t5_lat_first", 64'(rsp_cyc[1] - t0), 64'(4));
    chk("t5_lat_second", 64'(rsp_cyc[0] - t0), 64'(9));
    l2_hold = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT abandons the transaction
    l2_delay = 8;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h155, 32'h0);
    push_exp(0, 1'b0, 11'h155, 32'h0);
    fire();
    for (int i = 0; i < 20 && exp_cmd.size() != 0; i++) @(negedge clk);
    chk("t6_cmd_seen", 64'(exp_cmd.size()), 64'(0));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_rsp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    l2_delay = 2;
    set_req(0, 1'b1, 1'b0, 11'h166, 32'h0);
    push_exp(0, 1'b0, 11'h166, 32'h0);
    fire();
    t0 = pulse_cyc;
    drain(100);
    chk("t6_lat_after_rst", 64'(rsp_cyc[0] - t0), 64'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
